serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It complements the combinational adder blocks in the arithmetic library. It serves area-constrained datapaths that can trade latency for logic. A start/done handshake frames each operation, and results are held stable until the next operation completes.

---
 rtl/serial_subtractor_if.sv | 32 +++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Optional ovf signal present only when SUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SUB_SIGNED_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_SIGNED_OVF_EN
    output ovf,
`endif
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell + borrow reg.
// Define SUB_SIGNED_OVF_EN to add the registered signed-overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_nxt;
  logic             last;
  logic             accept;

  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0])
                | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && bus.start;

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: run WIDTH shifts, one DONE cycle, then idle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifting, borrow chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_sr   <= bus.a;
          b_sr   <= bus.b;
          res_sr <= '0;
          br     <= 1'b0;
          cnt    <= '0;
        end
        (state == SHIFT): begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= br_nxt;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded only on the final shift, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (state == SHIFT && last) begin
      diff_q   <= {d, res_sr[WIDTH-1:1]};
      borrow_q <= br_nxt;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  assign bus.ovf = ovf_q;

  // Keep operand signs; d on the last shift is the result sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == SHIFT && last) begin
      ovf_q <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor.
// Reference model is plain integer subtraction.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_diff(input int av, input int bv);
    int r;
    r = av - bv;
    if (r < 0) r += (1 << W);
    return W'(r);
  endfunction

  function automatic logic m_borrow(input int av, input int bv);
    return av < bv;
  endfunction

  function automatic logic m_ovf(input int av, input int bv);
    int sa;
    int sb;
    int r;
    sa = (av >= (1 << (W-1))) ? av - (1 << W) : av;
    sb = (bv >= (1 << (W-1))) ? bv - (1 << W) : bv;
    r  = sa - sb;
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  function automatic logic get_ovf();
`ifdef SUB_SIGNED_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one operation from an idle negedge; reports what was seen.
  task automatic do_op(
    input  logic [W-1:0] av,
    input  logic [W-1:0] bv,
    output logic [W-1:0] d,
    output logic         bo,
    output logic         ov,
    output int           lat,
    output int           busy_n,
    output bit           held,
    output bit           clean_end
  );
    logic [W-1:0] prev;
    prev      = bus.diff;
    held      = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    lat       = 1;
    busy_n    = 0;
    while (!bus.done && lat < 4 * W) begin
      if (bus.busy) busy_n++;
      if (bus.diff !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_n++;
    d  = bus.diff;
    bo = bus.borrow_out;
    ov = get_ovf();
    @(negedge clk);
    clean_end = !bus.done && !bus.busy;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.borrow_out, get_ovf()} !== 4'b0 ||
        bus.diff !== '0)
      $display("FAIL reset: busy=%b done=%b diff=%h bo=%b",
               bus.busy, bus.done, bus.diff, bus.borrow_out);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bn;
    bit held, ce;
    do_op(8'd200, 8'd55, d, bo, ov, lat, bn, held, ce);
    total++;
    if (lat !== W + 1)
      $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
    else pass_cnt++;
    total++;
    if (d !== 8'd145 || bo !== 1'b0)
      $display("FAIL basic_result: diff=%0d bo=%b want 145 0", d, bo);
    else pass_cnt++;
    total++;
    if (bn !== W + 1)
      $display("FAIL basic_busy: got %0d want %0d", bn, W + 1);
    else pass_cnt++;
    total++;
    if (!ce)
      $display("FAIL basic_pulse: done/busy high after DONE");
    else pass_cnt++;
  endtask

  task automatic test_borrow_hold();
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bn;
    bit held, ce;
    do_op(8'd5, 8'd10, d, bo, ov, lat, bn, held, ce);
    total++;
    if (d !== 8'hFB || bo !== 1'b1)
      $display("FAIL borrow: diff=%h bo=%b want fb 1", d, bo);
    else pass_cnt++;
    do_op(8'h5A, 8'h5A, d, bo, ov, lat, bn, held, ce);
    total++;
    if (d !== 8'h00 || bo !== 1'b0)
      $display("FAIL equal: diff=%h bo=%b want 00 0", d, bo);
    else pass_cnt++;
    total++;
    if (!held)
      $display("FAIL hold: previous diff changed before done");
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [W-1:0] d;
    dones     = 0;
    d         = '0;
    bus.a     = 8'd77;
    bus.b     = 8'd20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (bus.done) begin
        dones++;
        d = bus.diff;
      end
      @(negedge clk);
    end
    total++;
    if (dones !== 1)
      $display("FAIL ignore_done_count: got %0d want 1", dones);
    else pass_cnt++;
    total++;
    if (d !== m_diff(77, 20))
      $display("FAIL ignore_result: diff=%0d want %0d", d, m_diff(77, 20));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bn, dones;
    bit held, ce;
    dones     = 0;
    bus.a     = 8'd50;
    bus.b     = 8'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.diff !== '0 || bus.done !== 1'b0)
      $display("FAIL reset_mid: busy=%b diff=%h done=%b",
               bus.busy, bus.diff, bus.done);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total++;
    if (dones !== 0)
      $display("FAIL reset_mid_done: got %0d pulses want 0", dones);
    else pass_cnt++;
    do_op(8'd1, 8'd2, d, bo, ov, lat, bn, held, ce);
    total++;
    if (d !== 8'hFF || bo !== 1'b1)
      $display("FAIL after_reset: diff=%h bo=%b want ff 1", d, bo);
    else pass_cnt++;
  endtask

  task automatic test_held_start();
    int pulses[$];
    int n;
    bus.a     = 8'd9;
    bus.b     = 8'd4;
    bus.start = 1'b1;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses.push_back(n);
        total++;
        if (bus.diff !== 8'd5)
          $display("FAIL held_diff: at %0d diff=%0d want 5", n, bus.diff);
        else pass_cnt++;
      end
    end
    bus.start = 1'b0;
    total++;
    if (pulses.size() < 2 || pulses[0] !== 9 || pulses[1] !== 19)
      $display("FAIL held_timing: n=%0d first=%0d second=%0d want 9 19",
               pulses.size(),
               (pulses.size() > 0) ? pulses[0] : -1,
               (pulses.size() > 1) ? pulses[1] : -1);
    else pass_cnt++;
    n = 0;
    while (bus.busy && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.busy)
      $display("FAIL held_drain: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, d;
    logic bo, ov;
    int lat, bn, bad;
    bit held, ce;
    for (int i = 0; i < 24; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      if (i == 0) begin av = '0; bv = '1; end
      if (i == 1) begin av = '1; bv = '0; end
      do_op(av, bv, d, bo, ov, lat, bn, held, ce);
      bad = 0;
      if (d !== m_diff(av, bv)) bad = 1;
      if (bo !== m_borrow(av, bv)) bad = 1;
`ifdef SUB_SIGNED_OVF_EN
      if (ov !== m_ovf(av, bv)) bad = 1;
`endif
      if (lat !== W + 1) bad = 1;
      total++;
      if (bad != 0)
        $display("FAIL random: a=%h b=%h diff=%h bo=%b ov=%b lat=%0d want %h %b %b %0d",
                 av, bv, d, bo, ov, lat, m_diff(av, bv),
                 m_borrow(av, bv), m_ovf(av, bv), W + 1);
      else pass_cnt++;
    end
  endtask

`ifdef SUB_SIGNED_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bn;
    bit held, ce;
    do_op(8'h80, 8'h01, d, bo, ov, lat, bn, held, ce);
    total++;
    if (d !== 8'h7F || ov !== 1'b1)
      $display("FAIL ovf_set: diff=%h ovf=%b want 7f 1", d, ov);
    else pass_cnt++;
    do_op(8'h10, 8'h20, d, bo, ov, lat, bn, held, ce);
    total++;
    if (d !== 8'hF0 || ov !== 1'b0)
      $display("FAIL ovf_clear: diff=%h ovf=%b want f0 0", d, ov);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset();
    test_basic();
    test_borrow_hold();
    test_ignore_start();
    test_reset_mid();
    test_held_start();
    test_random();
`ifdef SUB_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
